// File: rtl/inta_sequencer.sv
// PIC8259 interrupt-acknowledge sequencer: raises INT, runs the two-pulse INTA
// handshake, maintains the In-Service Register and drives the vector byte.
module inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IRR,
  input  logic [4:0] Vector_Base,
  input  logic       AEOI,
  input  logic       INTA_N,
  input  logic       EOI_cmd,
  input  logic       EOI_specific,
  input  logic [2:0] EOI_level,
  output logic       INT,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic [7:0] ISR,
  output logic [7:0] Clear_IRR
);

  localparam int unsigned NLVL = 8;
  localparam int unsigned LW   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ACK1  = 3'd2,
    S_WAIT2 = 3'd3,
    S_ACK2  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            inta_prev_q;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic            spur_q, spur_d;
  logic            int_q, int_d;
  logic [NLVL-1:0] dout_q, dout_d;
  logic            doe_q, doe_d;
  logic [NLVL-1:0] isr_q, isr_d;
  logic [NLVL-1:0] clr_q, clr_d;

  logic            fall, rise;
  logic [NLVL-1:0] elig;
  logic            any_elig;
  logic [LW-1:0]   win;
  logic            blk;
  logic [NLVL-1:0] set_vec, eoi_clr, aeoi_clr;

  assign fall = ~INTA_N & inta_prev_q;
  assign rise = INTA_N & ~inta_prev_q;

  // Fully-nested eligibility: a level is blocked by any in-service level at or above it.
  always_comb begin
    blk  = 1'b0;
    elig = '0;
    win  = '0;
    for (int i = 0; i < int'(NLVL); i++) begin
      blk     = blk | isr_q[i];
      elig[i] = IRR[i] & ~blk;
    end
    for (int i = int'(NLVL) - 1; i >= 0; i--) begin
      if (elig[i]) win = LW'(i);
    end
    any_elig = |elig;
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    dout_d   = '0;
    set_vec  = '0;
    aeoi_clr = '0;
    eoi_clr  = '0;
    clr_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (any_elig) state_d = S_REQ;
      end
      S_REQ: begin
        if (fall) begin
          state_d = S_ACK1;
          lvl_d   = any_elig ? win : LW'(7);
          spur_d  = ~any_elig;
          if (any_elig) begin
            set_vec = NLVL'(1) << win;
            clr_d   = NLVL'(1) << win;
          end
        end else if (!any_elig) begin
          state_d = S_IDLE;
        end
      end
      S_ACK1: begin
        if (rise) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (fall) begin
          state_d = S_ACK2;
          dout_d  = {Vector_Base, lvl_q};
        end
      end
      S_ACK2: begin
        if (rise) begin
          state_d = S_IDLE;
          if (AEOI && !spur_q) aeoi_clr = NLVL'(1) << lvl_q;
        end else begin
          dout_d = dout_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // EOI target is taken from the pre-edge ISR; a coincident set on the same bit wins.
    if (EOI_cmd) begin
      if (EOI_specific) begin
        eoi_clr = NLVL'(1) << EOI_level;
      end else begin
        for (int i = int'(NLVL) - 1; i >= 0; i--) begin
          if (isr_q[i]) eoi_clr = NLVL'(1) << i;
        end
      end
    end

    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | set_vec;
    int_d = (state_d == S_REQ);
    doe_d = (state_d == S_ACK2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inta_prev_q <= 1'b1;
      lvl_q       <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      isr_q       <= '0;
      clr_q       <= '0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= INTA_N;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      isr_q       <= isr_d;
      clr_q       <= clr_d;
    end
  end

  assign INT       = int_q;
  assign D_OUT     = dout_q;
  assign D_OE      = doe_q;
  assign ISR       = isr_q;
  assign Clear_IRR = clr_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed self-checking bench for inta_sequencer.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] IRR;
  logic [4:0] Vector_Base;
  logic       AEOI;
  logic       INTA_N;
  logic       EOI_cmd;
  logic       EOI_specific;
  logic [2:0] EOI_level;
  logic       INT;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [7:0] ISR;
  logic [7:0] Clear_IRR;

  int checks   = 0;
  int failures = 0;

  inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .IRR(IRR), .Vector_Base(Vector_Base), .AEOI(AEOI),
    .INTA_N(INTA_N), .EOI_cmd(EOI_cmd), .EOI_specific(EOI_specific), .EOI_level(EOI_level),
    .INT(INT), .D_OUT(D_OUT), .D_OE(D_OE), .ISR(ISR), .Clear_IRR(Clear_IRR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full acknowledge of one request with no checking, used to set up ISR.
  task automatic run_ack(input logic [7:0] irr);
    IRR = irr;   tick();
    INTA_N = 0;  tick();
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0;  tick();
    INTA_N = 1;  tick();
  endtask

  task automatic eoi(input logic specific, input logic [2:0] lvl);
    EOI_cmd = 1; EOI_specific = specific; EOI_level = lvl; tick();
    EOI_cmd = 0; EOI_specific = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; IRR = 0; Vector_Base = 5'b01000; AEOI = 0; INTA_N = 1;
    EOI_cmd = 0; EOI_specific = 0; EOI_level = 0;
    tick(); tick();
    rst_n = 1; tick();
    checks++;
    if ({INT, D_OE, D_OUT, ISR, Clear_IRR} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs got INT=%b D_OE=%b D_OUT=%h ISR=%h CLR=%h exp all 0",
               INT, D_OE, D_OUT, ISR, Clear_IRR);
    end
  endtask

  task automatic test_basic();
    IRR = 8'h08; tick();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL basic_int got=%b exp=1", INT); end
    INTA_N = 0; tick();
    checks++; if (ISR !== 8'h08) begin failures++; $display("FAIL basic_isr_set got=%h exp=08", ISR); end
    checks++; if (Clear_IRR !== 8'h08) begin failures++; $display("FAIL basic_clr got=%h exp=08", Clear_IRR); end
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL basic_int_drop got=%b exp=0", INT); end
    IRR = 8'h00; INTA_N = 1; tick();
    checks++; if (Clear_IRR !== 8'h00) begin failures++; $display("FAIL basic_clr_pulse got=%h exp=00", Clear_IRR); end
    INTA_N = 0; tick();
    checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h43) begin
      failures++; $display("FAIL basic_vector got oe=%b dout=%h exp oe=1 dout=43", D_OE, D_OUT);
    end
    INTA_N = 1; tick();
    checks++; if (D_OE !== 1'b0 || D_OUT !== 8'h00 || ISR !== 8'h08) begin
      failures++; $display("FAIL basic_release got oe=%b dout=%h isr=%h exp 0/00/08", D_OE, D_OUT, ISR);
    end
  endtask

  task automatic test_nesting();
    IRR = 8'h28; tick(); tick();
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL nest_blocked got=%b exp=0", INT); end
    IRR = 8'h0A; tick();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL nest_int got=%b exp=1", INT); end
    INTA_N = 0; tick();
    checks++; if (ISR !== 8'h0A || Clear_IRR !== 8'h02) begin
      failures++; $display("FAIL nest_isr got isr=%h clr=%h exp 0a/02", ISR, Clear_IRR);
    end
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0; tick();
    checks++; if (D_OUT !== 8'h41) begin failures++; $display("FAIL nest_vector got=%h exp=41", D_OUT); end
    Vector_Base = 5'b10101; tick();
    checks++; if (D_OUT !== 8'h41) begin failures++; $display("FAIL nest_base_hold got=%h exp=41", D_OUT); end
    Vector_Base = 5'b01000; INTA_N = 1; tick();
    eoi(1'b0, 3'd0);
    checks++; if (ISR !== 8'h08) begin failures++; $display("FAIL nest_ns_eoi got=%h exp=08", ISR); end
    eoi(1'b1, 3'd3);
    checks++; if (ISR !== 8'h00) begin failures++; $display("FAIL nest_sp_eoi got=%h exp=00", ISR); end
  endtask

  task automatic test_aeoi();
    AEOI = 1; IRR = 8'h08; tick();
    INTA_N = 0; tick();
    checks++; if (ISR !== 8'h08) begin failures++; $display("FAIL aeoi_set got=%h exp=08", ISR); end
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0; tick();
    checks++; if (ISR !== 8'h08 || D_OUT !== 8'h43) begin
      failures++; $display("FAIL aeoi_ack2 got isr=%h dout=%h exp 08/43", ISR, D_OUT);
    end
    INTA_N = 1; tick();
    checks++; if (ISR !== 8'h00 || D_OE !== 1'b0) begin
      failures++; $display("FAIL aeoi_clear got isr=%h oe=%b exp 00/0", ISR, D_OE);
    end
    AEOI = 0;
  endtask

  task automatic test_spurious();
    IRR = 8'h01; tick();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL spur_int got=%b exp=1", INT); end
    IRR = 8'h00; INTA_N = 0; tick();
    checks++; if (ISR !== 8'h00 || Clear_IRR !== 8'h00 || INT !== 1'b0) begin
      failures++; $display("FAIL spur_ack1 got isr=%h clr=%h int=%b exp 00/00/0", ISR, Clear_IRR, INT);
    end
    INTA_N = 1; tick();
    INTA_N = 0; tick();
    checks++; if (D_OUT !== 8'h47 || D_OE !== 1'b1) begin
      failures++; $display("FAIL spur_vector got dout=%h oe=%b exp 47/1", D_OUT, D_OE);
    end
    INTA_N = 1; tick();
    checks++; if (ISR !== 8'h00) begin failures++; $display("FAIL spur_isr got=%h exp=00", ISR); end
  endtask

  task automatic test_simul_eoi();
    run_ack(8'h04);
    checks++; if (ISR !== 8'h04) begin failures++; $display("FAIL simul_setup got=%h exp=04", ISR); end
    IRR = 8'h02; tick();
    INTA_N = 0; EOI_cmd = 1; EOI_specific = 0; tick();
    EOI_cmd = 0;
    checks++; if (ISR !== 8'h02 || Clear_IRR !== 8'h02) begin
      failures++; $display("FAIL simul_eoi got isr=%h clr=%h exp 02/02", ISR, Clear_IRR);
    end
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0; tick();
    INTA_N = 1; tick();
    eoi(1'b1, 3'd1);
    checks++; if (ISR !== 8'h00) begin failures++; $display("FAIL simul_cleanup got=%h exp=00", ISR); end
  endtask

  task automatic test_reset_mid();
    IRR = 8'h01; tick();
    INTA_N = 0; tick();
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0; tick();
    checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h40) begin
      failures++; $display("FAIL rmid_ack2 got oe=%b dout=%h exp 1/40", D_OE, D_OUT);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({INT, D_OE, D_OUT, ISR, Clear_IRR} !== 26'd0) begin
      failures++;
      $display("FAIL rmid_async got INT=%b D_OE=%b D_OUT=%h ISR=%h CLR=%h exp all 0",
               INT, D_OE, D_OUT, ISR, Clear_IRR);
    end
    INTA_N = 1; tick();
    rst_n = 1; IRR = 8'h80; tick();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL rmid_int got=%b exp=1", INT); end
    INTA_N = 0; tick();
    checks++; if (ISR !== 8'h80 || Clear_IRR !== 8'h80) begin
      failures++; $display("FAIL rmid_isr got isr=%h clr=%h exp 80/80", ISR, Clear_IRR);
    end
    IRR = 8'h00; INTA_N = 1; tick();
    INTA_N = 0; tick();
    checks++; if (D_OUT !== 8'h47 || D_OE !== 1'b1) begin
      failures++; $display("FAIL rmid_vector got dout=%h oe=%b exp 47/1", D_OUT, D_OE);
    end
    INTA_N = 1; tick();
    checks++; if (D_OE !== 1'b0 || ISR !== 8'h80) begin
      failures++; $display("FAIL rmid_release got oe=%b isr=%h exp 0/80", D_OE, ISR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_aeoi();
    test_spurious();
    test_simul_eoi();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Interrupt-acknowledge and in-service sequencer of the PIC8259. It consumes the masked request vector produced by the request register and raises INT toward the CPU. It runs the two-pulse 8086-mode INTA handshake, freezes the winning level, maintains the In-Service Register, and drives the interrupt vector on the second pulse. It is the CPU-facing counterpart of the request-capture block and feeds a per-level clear pulse back to it.

## Interface
- No parameters; priority is fixed fully-nested, IR0 highest.
- clk  in  1  block clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IRR  in  8  masked interrupt requests from the request register.
- Vector_Base  in  5  T7..T3 from ICW2; forms vector bits [7:3].
- AEOI  in  1  1 = automatic EOI at end of second INTA pulse.
- INTA_N  in  1  CPU acknowledge strobe, active-low; synchronous to clk.
- EOI_cmd  in  1  one-cycle pulse: OCW2 EOI command.
- EOI_specific  in  1  qualifies EOI_cmd: 0 non-specific, 1 specific.
- EOI_level  in  3  target level for specific EOI.
- INT  out  1  interrupt request to CPU.
- D_OUT  out  8  vector byte.
- D_OE  out  1  D_OUT valid/drive enable.
- ISR  out  8  In-Service Register.
- Clear_IRR  out  8  one-hot, one-cycle pulse clearing the edge latch of the acknowledged level.

## Operation
- Eligible level i: IRR[i]=1 and ISR[j]=0 for all j<=i. Winner L is the lowest-numbered eligible level.
- Register inta_prev tracks INTA_N and resets to 1.
  - fall = (INTA_N==0 && inta_prev==1).
  - rise = (INTA_N==1 && inta_prev==0).
- States:
  - IDLE: INT=0. Any eligible level -> REQ.
  - REQ: INT=1.
    - fall: latch L (or L=7 with spurious=1 if nothing is eligible that cycle), set ISR[L] unless spurious, pulse Clear_IRR[L] unless spurious -> ACK1.
    - No fall and no eligible level: -> IDLE. The request was withdrawn.
  - ACK1: INT=0, D_OE=0. rise -> WAIT2.
  - WAIT2: fall -> ACK2. D_OUT={Vector_Base, L}, D_OE=1.
  - ACK2: D_OE holds 1. rise -> D_OE=0, and ISR[L] is cleared if AEOI=1 and not spurious -> IDLE.
- EOI handling (any state):
  - Non-specific EOI clears the lowest-numbered set ISR bit; no-op if ISR==0.
  - Specific EOI clears ISR[EOI_level].
- Simultaneous set and clear on the same cycle:
  - The clear target is computed from the pre-edge ISR.
  - If set and clear hit the same bit, set wins.
  - Distinct bits both apply.
- The latched L and Vector_Base are sampled at the second fall. Vector_Base changes after that do not alter D_OUT until the next cycle.
- D_OUT reads 0 whenever D_OE=0.

## Timing
- Reset values: INT=0, D_OUT=0, D_OE=0, ISR=0, Clear_IRR=0, state IDLE, inta_prev=1, L=0, spurious=0.
- Reset mid-handshake aborts to IDLE. A later INTA_N edge is treated as a new fall only from REQ/WAIT2.
- INT rises one cycle after an eligible request is first seen in IDLE. It falls on the edge that detects the first fall.
- ISR set and Clear_IRR pulse take effect at the edge detecting the first fall. Clear_IRR is high for exactly 1 cycle.
- D_OE and D_OUT are valid from the edge detecting the second fall through the edge detecting the second rise, when D_OE=0.
- AEOI clear lands on the same edge as D_OE deassertion.
- Once INT deasserts in ACK1, new requests do not re-raise INT until the sequence returns to IDLE.
- Minimum full cycle is IDLE->REQ->ACK1->WAIT2->ACK2->IDLE, 5 clocks with 1-cycle INTA pulses.
- INTA_N edges seen in IDLE or ACK1/ACK2 (other than rise) are ignored.

## Test plan
- Reset, then Vector_Base=5'b01000 and IRR=8'h08.
  - INT=1 next cycle.
  - First INTA pulse: ISR=8'h08, Clear_IRR=8'h08 for one cycle, INT=0.
  - Second pulse: D_OE=1, D_OUT=8'h43.
  - After release: D_OE=0, ISR stays 8'h08.
- Same sequence with AEOI=1: ISR returns to 8'h00 on the second rise.
- Nesting:
  - With ISR=8'h08 held, IRR=8'h28: INT stays 0 (IR5 blocked).
  - IRR=8'h0A: INT=1, acknowledge gives ISR=8'h0A and D_OUT={base,3'd1}.
  - Non-specific EOI: ISR=8'h08.
  - Specific EOI level 3: ISR=8'h00.
- Spurious: IRR=8'h01 raises INT, then IRR drops to 8'h00 in the same cycle as the first fall.
  - ISR unchanged, Clear_IRR=0, D_OUT={base,3'd7}.
- Simultaneous EOI: EOI_cmd non-specific with ISR=8'h04, on the same cycle as the first fall for IR1.
  - ISR=8'h02 afterward.
- Reset mid-operation: assert rst_n=0 during ACK2 with D_OE=1.
  - All outputs 0 immediately (asynchronous).
  - After release, IRR=8'h80 restarts cleanly with D_OUT={base,3'd7} and ISR=8'h80.
